// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int FIFO_AW    = 7;
  localparam int FIFO_DW    = 32;
  localparam int FIFO_DEPTH = 128;

  // Pointer carries one extra wrap bit above the memory address.
  typedef logic [FIFO_AW:0] ptr_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// registered read port. The array itself is never reset; only the read
// register clears so the consumer sees a known value after reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          ren_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rdata_q;

  // Store the incoming word at the write address when a write is accepted.
  always_ff @(posedge clk) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Capture the addressed word on an accepted read; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ren_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry an extra wrap bit so that equal
// addresses can be told apart as empty (same lap) or full (different lap).
// Requests that would overflow or underflow are dropped silently.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wenable,
  input  logic [DW-1:0] wdata,
  output logic          full,
  input  logic          renable,
  output logic [DW-1:0] rdata,
  output logic          empty
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        int_wenable;
  logic        int_renable;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign int_wenable = wenable & ~full;
  assign int_renable = renable & ~empty;

  // Advance each pointer only when its side's request is accepted.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (int_wenable) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (int_renable) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers; reset discards all stored words logically.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  sync_fifo_mem #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wen_i   (int_wenable),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (wdata),
    .ren_i   (int_renable),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 128;

  logic          clk;
  logic          rst;
  logic          wenable;
  logic [DW-1:0] wdata;
  logic          full;
  logic          renable;
  logic [DW-1:0] rdata;
  logic          empty;

  int cmpCount  = 0;
  int failCount = 0;

  // Reference model: the stored words in order, plus the last word read out.
  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] modelRdata;

  sync_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .wenable (wenable),
    .wdata   (wdata),
    .full    (full),
    .renable (renable),
    .rdata   (rdata),
    .empty   (empty)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every visible output against the model.
  task automatic checkAll(input string tag);
    checkOutput({tag, ".rdata"}, rdata, modelRdata);
    checkOutput({tag, ".empty"}, {31'd0, empty}, {31'd0, modelQ.size() == 0});
    checkOutput({tag, ".full"},  {31'd0, full},  {31'd0, modelQ.size() == DEPTH});
  endtask

  // Drive one cycle of requests, update the model at the edge, then check.
  task automatic applyStimulus(input logic wen, input logic ren,
                               input logic [DW-1:0] wd, input string tag);
    bit wasFull, wasEmpty;
    wenable = wen;
    renable = ren;
    wdata   = wd;
    @(posedge clk);
    wasFull  = (modelQ.size() == DEPTH);
    wasEmpty = (modelQ.size() == 0);
    if (ren && !wasEmpty) modelRdata = modelQ.pop_front();
    if (wen && !wasFull)  modelQ.push_back(wd);
    #1;
    checkAll(tag);
  endtask

  // Assert reset immediately, hold it for n edges, release after an edge.
  task automatic applyReset(input int n);
    wenable = 1'b0;
    renable = 1'b0;
    rst     = 1'b1;
    modelQ.delete();
    modelRdata = '0;
    #1;
    checkAll("resetAsync");
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll("resetRelease");
  endtask

  initial begin
    logic [DW-1:0] nextVal;
    rst     = 1'b0;
    wenable = 1'b0;
    renable = 1'b0;
    wdata   = '0;
    modelRdata = '0;
    @(posedge clk);
    #1;

    // 1. Reset then idle reads.
    applyReset(3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, '0, "idleRead");

    // 2. Fill and overflow.
    for (int k = 0; k < 140; k++) applyStimulus(1'b1, 1'b0, 1000 + 7 * k, "fill");

    // 3. Drain past empty.
    for (int k = 0; k < 140; k++) applyStimulus(1'b0, 1'b1, '0, "drain");
    checkOutput("drainHold", rdata, 32'd1889);

    // 4. Reset mid-operation.
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 500 + k, "preReset");
    applyReset(20);
    applyStimulus(1'b1, 1'b0, 32'd5, "postResetWr");
    applyStimulus(1'b0, 1'b1, '0, "postResetRd");
    checkOutput("postResetData", rdata, 32'd5);

    // 5. Alternating write/read traffic.
    nextVal = 2000;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(i % 2 == 0, i % 2 == 1, nextVal, "alternate");
      if (i % 2 == 0) nextVal += 3;
    end

    // 6a. Simultaneous request while full.
    applyReset(2);
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, 1'b0, 3000 + k, "fillAgain");
    applyStimulus(1'b1, 1'b1, 32'hDEAD, "bothAtFull");
    checkOutput("bothAtFullData", rdata, 32'd3000);
    for (int k = 0; k < DEPTH - 1; k++) applyStimulus(1'b0, 1'b1, '0, "drainAfterFull");
    checkOutput("lastBeforeEmpty", rdata, 32'd3000 + DEPTH - 1);

    // 6b. Simultaneous request while empty.
    applyStimulus(1'b1, 1'b1, 32'hBEEF, "bothAtEmpty");
    applyStimulus(1'b0, 1'b1, '0, "readBeef");
    checkOutput("beefData", rdata, 32'hBEEF);

    // Random traffic with occasional bias toward filling or draining.
    for (int i = 0; i < 2500; i++) begin
      int bias;
      bias = (i / 250) % 3;
      applyStimulus($urandom_range(0, 9) < (bias == 1 ? 8 : 5),
                    $urandom_range(0, 9) < (bias == 2 ? 8 : 5),
                    $urandom, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock first-in/first-out buffer: DEPTH words of DW bits.
- Independent write and read enables, with full and empty status flags.
- Sits between a producer and a consumer in the same clock domain; absorbs rate mismatch.
- Overflow writes and underflow reads are silently ignored. Read data is registered.

Parameters:
- AW, 7, address width; pointers are AW+1 bits (extra wrap bit).
- DW, 32, data word width.
- DEPTH, 128, number of storage words; must equal 2**AW.

Ports:
- clk  input  1  single clock for both write and read sides; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wenable  input  1  write request.
- wdata  input  DW  write data, sampled on the rising clk edge when the write is accepted.
- full  output  1  high when DEPTH words are stored.
- renable  input  1  read request.
- rdata  output  DW  registered read data.
- empty  output  1  high when no words are stored.

Behaviour:
- Reset (rst=1, asynchronous assert, released synchronously by the system):
  - write pointer and read pointer = 0; rdata = 0; empty = 1; full = 0.
  - Memory contents are not cleared.
- Pointers: wptr and rptr are AW+1 bits. The low AW bits address memory; the MSB toggles on each wrap.
  - empty = (wptr == rptr).
  - full = (MSBs differ) and (low AW bits equal).
  - Both flags are combinational from the registered pointers.
- Accepted write: int_wenable = wenable & ~full.
  - On the edge: mem[wptr[AW-1:0]] <= wdata; wptr <= wptr+1.
  - Writes while full are dropped; the pointer does not move.
- Accepted read: int_renable = renable & ~empty.
  - On the edge: rdata <= mem[rptr[AW-1:0]]; rptr <= rptr+1.
  - rdata is valid from the edge after acceptance (1-cycle latency).
  - rdata holds its last value when no read is accepted, including reads while empty.
- Flag timing: flags are evaluated on pre-edge pointer values.
  - Simultaneous write and read while full: the read is accepted, the write is dropped.
  - Simultaneous write and read while empty: the write is accepted, the read is ignored.
  - Simultaneous write and read otherwise: both are accepted and occupancy is unchanged.
- Latency: a word written on edge N is visible in rdata no earlier than edge N+1, i.e. a read accepted at N+1 shows it after N+1.
- Wrap-around: pointers increment modulo 2**(AW+1); addresses wrap modulo DEPTH with no special handling.
- Reset mid-operation: all stored data is discarded logically (pointers to 0, empty=1). Subsequent writes start at address 0.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - default constants FIFO_AW=7, FIFO_DW=32, FIFO_DEPTH=128;
  - a pointer typedef, logic [AW:0].
- One natural sub-module: sync_fifo_mem, a DEPTH x DW simple dual-port register array. It has one synchronous write port and one synchronous registered read port, with no reset on the array.
- Pointer and flag logic stays in sync_fifo.

Test Plan:
1. Reset then idle: rst high 3 cycles, then low → empty=1, full=0, rdata=0; renable pulses leave rdata=0 and empty=1.
2. Fill and overflow: after reset, hold wenable=1 for 140 cycles with wdata = 1000 + 7*k (k = 0..139) → words k=0..127 accepted; full rises after the 128th accepted write; writes k=128..139 dropped; empty=0 after the first write.
3. Drain: from the state after test 2, hold renable=1 for 140 cycles → rdata sequence 1000, 1007, …, 1000+7*127 on consecutive edges; empty rises after the 128th read; rdata then holds 1889; full drops after the first read.
4. Reset mid-operation: write 10 words, assert rst for 20 cycles, release → empty=1, full=0, rdata=0. Write 5 (value 5) then read → rdata=5 (old data not returned).
5. Simultaneous traffic: toggle wenable every cycle from wdata=2000 step 3, and toggle renable offset by one cycle → every read returns words in order 2000, 2003, …; empty never asserted with a pending read mismatch; full never asserts.
6. Boundary simultaneity:
   - At full (128 words), assert wenable and renable in the same cycle with wdata=0xDEAD → the oldest word is read, 0xDEAD is dropped, occupancy becomes 127.
   - At empty, assert both with wdata=0xBEEF → rdata unchanged, occupancy becomes 1; the next read returns 0xBEEF.
